// File: rtl/sirv_qspi_media.sv
// QSPI media layer: turns link-layer frame bytes into physical ops (config, CS delays, data),
// owns the active-low chip select and converts the physical level-type done into rx pulses.
module sirv_qspi_media #(
   parameter int DLA_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [11:0]      io_ctrl_sck_div,
   input  logic             io_ctrl_sck_pol,
   input  logic             io_ctrl_sck_pha,
   input  logic [DLA_W-1:0] io_ctrl_dla_cssck,
   input  logic [DLA_W-1:0] io_ctrl_dla_sckcs,
   input  logic [DLA_W-1:0] io_ctrl_dla_icss,
   input  logic [1:0]       io_ctrl_cs_mode,
   input  logic             io_link_valid,
   output logic             io_link_ready,
   input  logic [7:0]       io_link_data,
   input  logic [7:0]       io_link_cnt,
   input  logic             io_link_last,
   input  logic [1:0]       io_link_proto,
   input  logic             io_link_endian,
   input  logic             io_link_iodir,
   output logic             io_link_active,
   output logic             io_link_rx_valid,
   output logic [7:0]       io_link_rx_bits,
   output logic             io_op_valid,
   input  logic             io_op_ready,
   output logic             io_op_fn,
   output logic             io_op_stb,
   output logic [7:0]       io_op_cnt,
   output logic [7:0]       io_op_data,
   output logic [11:0]      io_op_sck_div,
   output logic             io_op_sck_pol,
   output logic             io_op_sck_pha,
   output logic [1:0]       io_op_proto,
   output logic             io_op_endian,
   output logic             io_op_iodir,
   input  logic             io_phy_rx_valid,
   input  logic [7:0]       io_phy_rx_bits,
   output logic             io_port_cs
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_CSSCK, S_DATA, S_SCKCS, S_ICS
   } state_e;

   state_e      state_q;
   logic        cs_q;
   logic        opv_q;
   logic [7:0]  cnt_q;
   logic [11:0] sck_div_q;
   logic        sck_pol_q;
   logic        sck_pha_q;
   logic        frame_end_q;
   logic        rx_pend_q, rx_pend_d;
   logic        rx_vld_q;
   logic [7:0]  rx_bits_q;

   logic mode_off, mode_hold, mode_auto;
   logic in_data, link_xfer, rx_cap, sckcs_go;

   assign mode_off  = (io_ctrl_cs_mode == 2'd3);
   assign mode_hold = (io_ctrl_cs_mode == 2'd2);
   assign mode_auto = !mode_off && !mode_hold;

   assign in_data   = (state_q == S_DATA);
   assign link_xfer = in_data && io_link_valid && io_op_ready;
   assign rx_cap    = rx_pend_q && io_phy_rx_valid;

   // HOLD/OFF only release CS at a frame boundary once the mode returns to AUTO
   assign sckcs_go = link_xfer ? (io_link_last && mode_auto)
                               : (mode_auto && frame_end_q && !io_link_valid);

   // A new transfer re-arms the pending flag even when it coincides with a capture
   always_comb begin
      rx_pend_d = rx_pend_q;
      if (link_xfer && io_link_cnt != 8'd0)
         rx_pend_d = 1'b1;
      else if (rx_cap)
         rx_pend_d = 1'b0;
   end

   // Data ops pass straight through from the link; every other op comes from registers
   assign io_op_valid   = in_data ? io_link_valid : opv_q;
   assign io_op_fn      = !in_data;
   assign io_op_stb     = in_data || (state_q == S_CFG);
   assign io_op_cnt     = in_data ? io_link_cnt : cnt_q;
   assign io_op_data    = in_data ? io_link_data : 8'h00;
   assign io_op_proto   = in_data ? io_link_proto : 2'b00;
   assign io_op_endian  = in_data && io_link_endian;
   assign io_op_iodir   = in_data && io_link_iodir;
   assign io_op_sck_div = sck_div_q;
   assign io_op_sck_pol = sck_pol_q;
   assign io_op_sck_pha = sck_pha_q;

   assign io_link_ready    = link_xfer;
   assign io_link_active   = (state_q != S_IDLE);
   assign io_link_rx_valid = rx_vld_q;
   assign io_link_rx_bits  = rx_bits_q;
   assign io_port_cs       = cs_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cs_q        <= 1'b1;
         opv_q       <= 1'b0;
         cnt_q       <= 8'd0;
         sck_div_q   <= 12'd0;
         sck_pol_q   <= 1'b0;
         sck_pha_q   <= 1'b0;
         frame_end_q <= 1'b0;
         rx_pend_q   <= 1'b0;
         rx_vld_q    <= 1'b0;
         rx_bits_q   <= 8'd0;
      end else begin
         rx_pend_q <= rx_pend_d;
         rx_vld_q  <= rx_cap;
         if (rx_cap)
            rx_bits_q <= io_phy_rx_bits;

         unique case (state_q)
            S_IDLE: begin
               if (io_link_valid) begin
                  // SCK settings frozen here so the config op stays stable while stalled
                  state_q   <= S_CFG;
                  opv_q     <= 1'b1;
                  cnt_q     <= 8'd0;
                  sck_div_q <= io_ctrl_sck_div;
                  sck_pol_q <= io_ctrl_sck_pol;
                  sck_pha_q <= io_ctrl_sck_pha;
               end
            end
            S_CFG: begin
               if (io_op_ready) begin
                  state_q <= S_CSSCK;
                  cs_q    <= mode_off;
                  cnt_q   <= 8'(io_ctrl_dla_cssck);
                  opv_q   <= (io_ctrl_dla_cssck != '0) && !mode_off;
               end
            end
            S_CSSCK: begin
               if (!opv_q || io_op_ready) begin
                  state_q     <= S_DATA;
                  opv_q       <= 1'b0;
                  frame_end_q <= 1'b0;
               end
            end
            S_DATA: begin
               if (link_xfer)
                  frame_end_q <= io_link_last;
               if (sckcs_go) begin
                  state_q <= S_SCKCS;
                  cnt_q   <= 8'(io_ctrl_dla_sckcs);
                  opv_q   <= (io_ctrl_dla_sckcs != '0) && !mode_off;
               end
            end
            S_SCKCS: begin
               if (!opv_q || io_op_ready) begin
                  state_q <= S_ICS;
                  cs_q    <= 1'b1;
                  cnt_q   <= 8'(io_ctrl_dla_icss);
                  opv_q   <= (io_ctrl_dla_icss != '0);
               end
            end
            S_ICS: begin
               if (!opv_q || io_op_ready) begin
                  state_q <= S_IDLE;
                  opv_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               opv_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sirv_qspi_media.sv
// Directed bench for sirv_qspi_media with a small loopback physical-stage model.
module tb_sirv_qspi_media;
   localparam int DLA_W = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [11:0]      sck_div = 12'd0;
   logic             sck_pol = 1'b0, sck_pha = 1'b0;
   logic [DLA_W-1:0] dla_cssck = '0, dla_sckcs = '0, dla_icss = '0;
   logic [1:0]       cs_mode = 2'd0;
   logic             link_valid = 1'b0, link_last = 1'b0;
   logic             link_endian = 1'b0, link_iodir = 1'b0;
   logic [7:0]       link_data = 8'd0, link_cnt = 8'd0;
   logic [1:0]       link_proto = 2'd0;
   logic             link_ready, link_active, link_rx_valid;
   logic [7:0]       link_rx_bits;
   logic             op_valid, op_ready, op_fn, op_stb;
   logic [7:0]       op_cnt, op_data;
   logic [11:0]      op_sck_div;
   logic             op_sck_pol, op_sck_pha, op_endian, op_iodir;
   logic [1:0]       op_proto;
   logic             phy_rx_valid = 1'b0;
   logic [7:0]       phy_rx_bits = 8'd0;
   logic             port_cs;

   int ntests = 0;
   int nfail  = 0;

   sirv_qspi_media #(.DLA_W(DLA_W)) dut (
      .clock(clock), .reset(reset),
      .io_ctrl_sck_div(sck_div), .io_ctrl_sck_pol(sck_pol), .io_ctrl_sck_pha(sck_pha),
      .io_ctrl_dla_cssck(dla_cssck), .io_ctrl_dla_sckcs(dla_sckcs), .io_ctrl_dla_icss(dla_icss),
      .io_ctrl_cs_mode(cs_mode),
      .io_link_valid(link_valid), .io_link_ready(link_ready), .io_link_data(link_data),
      .io_link_cnt(link_cnt), .io_link_last(link_last), .io_link_proto(link_proto),
      .io_link_endian(link_endian), .io_link_iodir(link_iodir), .io_link_active(link_active),
      .io_link_rx_valid(link_rx_valid), .io_link_rx_bits(link_rx_bits),
      .io_op_valid(op_valid), .io_op_ready(op_ready), .io_op_fn(op_fn), .io_op_stb(op_stb),
      .io_op_cnt(op_cnt), .io_op_data(op_data), .io_op_sck_div(op_sck_div),
      .io_op_sck_pol(op_sck_pol), .io_op_sck_pha(op_sck_pha), .io_op_proto(op_proto),
      .io_op_endian(op_endian), .io_op_iodir(op_iodir),
      .io_phy_rx_valid(phy_rx_valid), .io_phy_rx_bits(phy_rx_bits),
      .io_port_cs(port_cs)
   );

   always #5 clock = ~clock;

   // Physical model: busy after each op, data ops loop tx back as a level-type done
   logic       tb_rdy = 1'b1;
   int         ph_cnt = 0;
   logic       ph_dat = 1'b0;
   logic [7:0] ph_tx  = 8'd0;
   assign op_ready = tb_rdy && (ph_cnt == 0);

   always @(posedge clock) begin
      if (op_valid && op_ready) begin
         phy_rx_valid <= 1'b0;
         ph_dat       <= !op_fn;
         ph_tx        <= op_data;
         ph_cnt       <= (!op_fn && op_cnt != 8'd0) ? 3 : 1;
      end else if (ph_cnt != 0) begin
         ph_cnt <= ph_cnt - 1;
         if (ph_cnt == 1 && ph_dat) begin
            phy_rx_valid <= 1'b1;
            phy_rx_bits  <= ph_tx;
         end
      end
   end

   function automatic logic [21:0] mk(logic iodir, logic endian, logic [1:0] proto,
                                      logic stb, logic fn, logic [7:0] cnt, logic [7:0] data);
      return {iodir, endian, proto, stb, fn, cnt, data};
   endfunction

   function automatic logic [21:0] op_cfg();
      return mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 8'd0, 8'd0);
   endfunction

   function automatic logic [21:0] op_dly(logic [7:0] n);
      return mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, n, 8'd0);
   endfunction

   function automatic logic [21:0] op_dat(logic [7:0] c, logic [7:0] d);
      return mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, c, d);
   endfunction

   // Monitor: the only writer of the logs; tests take snapshots of the counters
   logic [21:0] op_log[64];
   logic        op_cs[64];
   logic [13:0] op_sck[64];
   logic [7:0]  rx_log[64];
   int nop = 0, nrx = 0, cs_low_n = 0;

   always @(negedge clock) begin
      if (!reset) begin
         if (op_valid && op_ready) begin
            if (nop < 64) begin
               op_log[nop] = mk(op_iodir, op_endian, op_proto, op_stb, op_fn, op_cnt, op_data);
               op_cs[nop]  = port_cs;
               op_sck[nop] = {op_sck_pol, op_sck_pha, op_sck_div};
            end
            nop++;
         end
         if (link_rx_valid) begin
            if (nrx < 64) rx_log[nrx] = link_rx_bits;
            nrx++;
         end
         if (!port_cs) cs_low_n++;
      end
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      for (int t = 0; t < 300; t++) begin
         @(negedge clock);
         if (link_ready) return;
      end
      check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 300; t++) begin
         @(negedge clock);
         if (!link_active) return;
      end
      check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic settle();
      repeat (8) @(negedge clock);
   endtask

   // Sends n bytes back to back; link_valid stays high between bytes
   logic [7:0] f_data[8], f_cnt[8];
   task automatic send_frame(int n, logic last_at_end);
      @(posedge clock); #1;
      for (int i = 0; i < n; i++) begin
         link_valid = 1'b1;
         link_data  = f_data[i];
         link_cnt   = f_cnt[i];
         link_last  = (i == n - 1) && last_at_end;
         wait_ready();
         @(posedge clock); #1;
      end
      link_valid = 1'b0;
      link_last  = 1'b0;
   endtask

   int b, br, bc;

   initial begin
      repeat (2) @(negedge clock);
      check("rst_cs", port_cs, 1);
      check("rst_op_valid", op_valid, 0);
      check("rst_link_ready", link_ready, 0);
      check("rst_rx_valid", link_rx_valid, 0);
      check("rst_rx_bits", link_rx_bits, 0);
      check("rst_active", link_active, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // AUTO, delays 1/1/1, single byte with non-default format fields
      sck_div = 12'h123; sck_pol = 1'b1; sck_pha = 1'b0;
      dla_cssck = 8'd1; dla_sckcs = 8'd1; dla_icss = 8'd1; cs_mode = 2'd0;
      link_proto = 2'd2; link_endian = 1'b1; link_iodir = 1'b1;
      b = nop; br = nrx;
      f_data[0] = 8'hA5; f_cnt[0] = 8'd8;
      send_frame(1, 1'b1);
      wait_idle(); settle();
      link_proto = 2'd0; link_endian = 1'b0; link_iodir = 1'b0;
      check("t1_nop", nop - b, 5);
      check("t1_op0_cfg", op_log[b], op_cfg());
      check("t1_op0_sck", op_sck[b], {1'b1, 1'b0, 12'h123});
      check("t1_op1_cssck", op_log[b+1], op_dly(8'd1));
      check("t1_op2_data", op_log[b+2], mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8'd8, 8'hA5));
      check("t1_op3_sckcs", op_log[b+3], op_dly(8'd1));
      check("t1_op4_icss", op_log[b+4], op_dly(8'd1));
      check("t1_cs_at_cfg", op_cs[b], 1);
      check("t1_cs_at_cssck", op_cs[b+1], 0);
      check("t1_cs_at_sckcs", op_cs[b+3], 0);
      check("t1_cs_at_icss", op_cs[b+4], 1);
      check("t1_nrx", nrx - br, 1);
      check("t1_rx0", rx_log[br], 8'hA5);

      // AUTO, all delays zero, three-byte frame
      dla_cssck = 8'd0; dla_sckcs = 8'd0; dla_icss = 8'd0;
      b = nop; br = nrx;
      f_data[0] = 8'h11; f_data[1] = 8'h22; f_data[2] = 8'h33;
      f_cnt[0] = 8'd8; f_cnt[1] = 8'd8; f_cnt[2] = 8'd8;
      send_frame(3, 1'b1);
      wait_idle(); settle();
      check("t2_nop", nop - b, 4);
      check("t2_op0_cfg", op_log[b], op_cfg());
      check("t2_op3_data", op_log[b+3], op_dat(8'd8, 8'h33));
      check("t2_cs_d0", op_cs[b+1], 0);
      check("t2_cs_d1", op_cs[b+2], 0);
      check("t2_cs_d2", op_cs[b+3], 0);
      check("t2_nrx", nrx - br, 3);
      check("t2_rx0", rx_log[br], 8'h11);
      check("t2_rx1", rx_log[br+1], 8'h22);
      check("t2_rx2", rx_log[br+2], 8'h33);
      check("t2_cs_end", port_cs, 1);

      // HOLD across two frames, then release with AUTO
      dla_sckcs = 8'd2; cs_mode = 2'd2;
      b = nop; br = nrx;
      f_data[0] = 8'hC1; f_cnt[0] = 8'd8;
      send_frame(1, 1'b1);
      settle();
      f_data[0] = 8'hC2;
      send_frame(1, 1'b1);
      settle();
      check("t3_cs_held", port_cs, 0);
      check("t3_active", link_active, 1);
      check("t3_nop_held", nop - b, 3);
      check("t3_cs_frame2", op_cs[b+2], 0);
      @(posedge clock); #1;
      cs_mode = 2'd0;
      wait_idle(); settle();
      check("t3_nop", nop - b, 4);
      check("t3_sckcs", op_log[b+3], op_dly(8'd2));
      check("t3_cs_end", port_cs, 1);
      check("t3_nrx", nrx - br, 2);

      // OFF: CS never asserted, data and rx still flow
      dla_cssck = 8'd3; dla_sckcs = 8'd3; dla_icss = 8'd0; cs_mode = 2'd3;
      b = nop; br = nrx; bc = cs_low_n;
      f_data[0] = 8'h4E; f_data[1] = 8'hB7; f_cnt[0] = 8'd8; f_cnt[1] = 8'd4;
      send_frame(2, 1'b1);
      settle();
      check("t4_nrx", nrx - br, 2);
      check("t4_rx0", rx_log[br], 8'h4E);
      check("t4_rx1", rx_log[br+1], 8'hB7);
      check("t4_op2_data", op_log[b+2], op_dat(8'd4, 8'hB7));
      @(posedge clock); #1;
      cs_mode = 2'd0;
      wait_idle(); settle();
      check("t4_nop", nop - b, 4);
      check("t4_sckcs", op_log[b+3], op_dly(8'd3));
      check("t4_cs_low_cycles", cs_low_n - bc, 0);

      // Physical stall for five cycles in DATA
      dla_cssck = 8'd0; dla_sckcs = 8'd0; dla_icss = 8'd0;
      b = nop; br = nrx;
      @(posedge clock); #1;
      link_valid = 1'b1; link_data = 8'h5A; link_cnt = 8'd8; link_last = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(posedge clock); #1;
         if (op_valid && !op_fn) break;
      end
      tb_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("t5_valid", op_valid, 1);
         check("t5_data", op_data, 8'h5A);
         check("t5_cnt", op_cnt, 8'd8);
         check("t5_link_ready", link_ready, 0);
      end
      @(posedge clock); #1;
      tb_rdy = 1'b1;
      wait_ready();
      @(posedge clock); #1;
      link_valid = 1'b0; link_last = 1'b0;
      wait_idle(); settle();
      check("t5_nop", nop - b, 2);
      check("t5_op1", op_log[b+1], op_dat(8'd8, 8'h5A));
      check("t5_nrx", nrx - br, 1);
      check("t5_rx0", rx_log[br], 8'h5A);

      // Zero-count byte produces no rx
      b = nop; br = nrx;
      f_data[0] = 8'h77; f_data[1] = 8'h3C; f_cnt[0] = 8'd0; f_cnt[1] = 8'd8;
      send_frame(2, 1'b1);
      wait_idle(); settle();
      check("t6_op1", op_log[b+1], op_dat(8'd0, 8'h77));
      check("t6_nrx", nrx - br, 1);
      check("t6_rx0", rx_log[br], 8'h3C);

      // Reset mid-DATA with an rx pending
      br = nrx;
      f_data[0] = 8'hE1; f_cnt[0] = 8'd8;
      send_frame(1, 1'b0);
      check("t7_cs_before", port_cs, 0);
      reset = 1'b1;
      #1;
      check("t7_cs_reset", port_cs, 1);
      check("t7_active_reset", link_active, 0);
      check("t7_opv_reset", op_valid, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      settle();
      check("t7_no_rx", nrx - br, 0);
      b = nop; br = nrx;
      f_data[0] = 8'h96; f_cnt[0] = 8'd8;
      send_frame(1, 1'b1);
      wait_idle(); settle();
      check("t7_next_cfg", op_log[b], op_cfg());
      check("t7_nrx", nrx - br, 1);
      check("t7_rx0", rx_log[br], 8'h96);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
